memoria_datos: RTL and testbench
================================

# memoria_datos

Parametrised byte-addressable data memory for the RISC-V core's MEM stage. It replaces the fixed 8-bit/32-bit store-only memory with a valid/ready request port, byte/half/word loads and stores, sign/zero extension, range checking and an error flag. Storage is word-organised with byte enables. Accesses that cross a word boundary either fault or are split into two cycles, selected at compile time.

## Interface
- DEPTH_BYTES, 256: memory size in bytes; must be a power of two and at least 8.
- ADDR_W, 8: byte-address bits actually decoded; must equal log2(DEPTH_BYTES).
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data, least-significant bytes used.
- rsp_valid  out  1  one-cycle pulse, response available.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted, qualified by rsp_valid.

## Operation
- A request is accepted on a rising edge where req_valid && req_ready.
- Byte offset: off = req_addr[1:0]. Byte count: n = 1, 2 or 4.
- Crossing access: off + n > 4.
- Error on any of the following: req_size == 11; req_addr[31:ADDR_W] != 0; the last byte (addr + n - 1) falls outside memory. An errored request writes nothing and returns rsp_err=1 with rsp_rdata=0.
- Stores write little-endian: req_wdata[7:0] goes to the lowest address.
- Loads assemble little-endian, then extend from bit 7 (byte) or bit 15 (half).
- FSM states:
  - IDLE: req_ready=1.
  - SPLIT: req_ready=0; performs the second word of a crossing access.
- Transitions:
  - IDLE → SPLIT on accepting a non-errored crossing access (only when the feature is compiled in).
  - SPLIT → IDLE after one cycle, unconditionally.
- No response backpressure; a consumer must take rsp_* in the cycle rsp_valid is high.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- Reset values:
  - state = IDLE, so req_ready=1 in the cycle after reset.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Non-crossing access and any error: memory is written or read at the acceptance edge. rsp_valid=1 in the following cycle, so latency is 1. The next request can be accepted back-to-back.
- Crossing access: the low word is written/read at the acceptance edge and the high word at the next edge. rsp_valid follows the second edge, so latency is 2. req_ready=0 for exactly one cycle.
- rsp_rdata and rsp_err are registered and hold their value until the next response.
- A load accepted in the cycle after a store to the same bytes returns the new data; the write has completed at the earlier edge.
- Reset during SPLIT: a store's first word stays written, its second word is dropped, and no response is produced.

## Configuration
- MEM_MISALIGN_SPLIT_EN defined: crossing accesses execute as a two-cycle split, as described above.
- MEM_MISALIGN_SPLIT_EN undefined:
  - Crossing accesses are errors (rsp_err=1, no write, latency 1).
  - SPLIT state is absent and req_ready is tied to 1.

## Structure
- Package mem_pkg holds:
  - the size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum {ST_IDLE, ST_SPLIT};
  - a function returning the byte count for a size.
- Sub-module mem_word_ram:
  - DEPTH_BYTES/4 words of 32 bits;
  - one port with address, a 4-bit byte-enable write and synchronous read.
  - It is instantiated once; alignment, extension and the FSM live in memoria_datos.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, latency 1.
- Load byte at 0x13, req_unsigned=0 → 0xFFFFFFDE. Same load with req_unsigned=1 → 0x000000DE.
- Store half 0x1234 at 0x21, then load word at 0x20 → bytes 0x21/0x22 = 0x34/0x12, other bytes unchanged.
- Store word 0xA1B2C3D4 at 0x0E:
  - with the macro: req_ready low for 1 cycle, and a load word at 0x0E returns 0xA1B2C3D4 with latency 2;
  - without the macro: rsp_err=1 and memory at 0x0C–0x13 is unchanged.
- Load word at 0x100 (DEPTH_BYTES=256), and a load with req_size=11 → rsp_err=1, rsp_rdata=0.
- Assert reset in the SPLIT cycle of a crossing store → no rsp_valid, req_ready=1 the next cycle, only the low word is written.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, FSM state type and byte-count helper for memoria_datos
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - single-port word RAM with byte-enable writes and synchronous read
module mem_word_ram #(
  parameter int WORDS = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memoria_datos.sv
// rtl/memoria_datos.sv - MEM-stage data memory; define MEM_MISALIGN_SPLIT_EN to split word-crossing accesses over two cycles
module memoria_datos
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;

  logic [1:0]         off;
  logic [2:0]         nbytes;
  logic [ADDR_W:0]    last_byte;
  logic               crossing, req_err, accept;
  logic [7:0]         be64;
  logic [63:0]        wdata64;
  logic [WORD_AW-1:0] word_addr;

  logic               ram_en, ram_we;
  logic [3:0]         ram_be;
  logic [WORD_AW-1:0] ram_addr;
  logic [31:0]        ram_wdata, ram_rdata;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;
  logic [1:0]  rsp_off_q, rsp_off_d;
  logic [1:0]  rsp_size_q, rsp_size_d;
  logic        rsp_uns_q, rsp_uns_d;
  logic [31:0] hold_q, hold_d;
  logic [63:0] rd_data64;
  logic [31:0] rd_shift, rd_ext;

`ifdef MEM_MISALIGN_SPLIT_EN
  state_e             state_q, state_d;
  logic [WORD_AW-1:0] split_addr_q, split_addr_d;
  logic [3:0]         split_be_q, split_be_d;
  logic [31:0]        split_wdata_q, split_wdata_d;
  logic               split_we_q, split_we_d;
  logic [31:0]        lo_word_q, lo_word_d;
  logic               rsp_split_q, rsp_split_d;

  assign req_ready = (state_q == ST_IDLE);
`else
  logic unused_hi;

  assign unused_hi = ^{be64[7:4], wdata64[63:32]};
  assign req_ready = 1'b1;
`endif

  // Request decode: the byte enables and data are laid out over two words so a crossing access keeps its upper half
  always_comb begin
    off       = req_addr[1:0];
    nbytes    = size_bytes(req_size);
    crossing  = ({1'b0, off} + nbytes) > 3'd4;
    last_byte = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    req_err   = (req_size == SZ_RSVD) || ((req_addr >> ADDR_W) != 32'd0) || last_byte[ADDR_W];
`ifndef MEM_MISALIGN_SPLIT_EN
    req_err   = req_err || crossing;
`endif
    be64      = ((req_size == SZ_BYTE) ? 8'h01 : (req_size == SZ_HALF) ? 8'h03 : 8'h0F) << off;
    wdata64   = {32'h0, req_wdata} << {off, 3'b000};
    word_addr = req_addr[ADDR_W-1:2];
    accept    = req_valid && req_ready && !reset;
  end

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_be      = be64[3:0];
    ram_addr    = word_addr;
    ram_wdata   = wdata64[31:0];
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    rsp_off_d   = rsp_off_q;
    rsp_size_d  = rsp_size_q;
    rsp_uns_d   = rsp_uns_q;
    hold_d      = rsp_valid_q ? rd_ext : hold_q;
`ifdef MEM_MISALIGN_SPLIT_EN
    state_d       = state_q;
    split_addr_d  = split_addr_q;
    split_be_d    = split_be_q;
    split_wdata_d = split_wdata_q;
    split_we_d    = split_we_q;
    lo_word_d     = lo_word_q;
    rsp_split_d   = rsp_split_q;
    if (state_q == ST_SPLIT) begin
      state_d     = ST_IDLE;
      ram_en      = 1'b1;
      ram_we      = split_we_q;
      ram_be      = split_be_q;
      ram_addr    = split_addr_q;
      ram_wdata   = split_wdata_q;
      lo_word_d   = ram_rdata;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b0;
    end else
`endif
    if (accept) begin
      rsp_load_d = !req_we && !req_err;
      rsp_off_d  = off;
      rsp_size_d = req_size;
      rsp_uns_d  = req_unsigned;
      if (!req_err) begin
        ram_en = 1'b1;
        ram_we = req_we;
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      rsp_split_d = 1'b0;
      if (!req_err && crossing) begin
        state_d       = ST_SPLIT;
        split_addr_d  = word_addr + WORD_AW'(1);
        split_be_d    = be64[7:4];
        split_wdata_d = wdata64[63:32];
        split_we_d    = req_we;
        rsp_split_d   = 1'b1;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = req_err;
      end
`else
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
`endif
    end
    // Reset in the SPLIT cycle must drop the second word
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_comb begin
`ifdef MEM_MISALIGN_SPLIT_EN
    rd_data64 = rsp_split_q ? {ram_rdata, lo_word_q} : {32'h0, ram_rdata};
`else
    rd_data64 = {32'h0, ram_rdata};
`endif
    rd_shift = 32'(rd_data64 >> {rsp_off_q, 3'b000});
    case (rsp_size_q)
      SZ_BYTE: rd_ext = {{24{~rsp_uns_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rd_ext = {{16{~rsp_uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
    if (!rsp_load_q) rd_ext = 32'h0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      hold_q      <= 32'h0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      hold_q      <= hold_d;
    end
    rsp_off_q  <= rsp_off_d;
    rsp_size_q <= rsp_size_d;
    rsp_uns_q  <= rsp_uns_d;
  end

`ifdef MEM_MISALIGN_SPLIT_EN
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
    split_addr_q  <= split_addr_d;
    split_be_q    <= split_be_d;
    split_wdata_q <= split_wdata_d;
    split_we_q    <= split_we_d;
    lo_word_q     <= lo_word_d;
    rsp_split_q   <= rsp_split_d;
  end
`endif

  // Between responses the output shows the last delivered value
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_valid_q ? rd_ext : hold_q;
  assign rsp_err   = rsp_err_q;

  mem_word_ram #(
    .WORDS (DEPTH_BYTES / 4),
    .AW    (WORD_AW)
  ) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_memoria_datos.sv
// tb/tb_memoria_datos.sv - directed self-checking bench for memoria_datos (both MEM_MISALIGN_SPLIT_EN builds)
module tb_memoria_datos;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;
  int          r_low;

  memoria_datos #(.DEPTH_BYTES(256), .ADDR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clock = ~clock;

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int waited;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: req_ready=%0b required 1", req_ready); end
    @(posedge clock);
    #1 req_valid = 1'b0;
    r_lat = 0; r_low = 0; r_data = 32'hxxxxxxxx; r_err = 1'bx;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (!req_ready) r_low++;
      if (rsp_valid) begin
        r_lat = i; r_data = rsp_rdata; r_err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", rsp_err); end
  endtask

  task automatic test_word();
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (r_lat != 1) begin errors++; $display("FAIL st_word_lat: got %0d want 1", r_lat); end
    checks++; if (r_err !== 1'b0 || r_data !== 32'h0) begin errors++; $display("FAIL st_word_rsp: got err=%0b data=%h want err=0 data=0", r_err, r_data); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_lat != 1) begin errors++; $display("FAIL ld_word_lat: got %0d want 1", r_lat); end
    checks++; if (r_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_data: got %h want deadbeef", r_data); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ld_word_err: got %0b want 0", r_err); end
    repeat (2) @(negedge clock);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %0b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_rdata: got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_extend();
    logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, sz[i], un[i], ad[i], 32'h0);
      checks++;
      if (r_data !== exp[i] || r_err !== 1'b0 || r_lat != 1) begin
        errors++;
        $display("FAIL extend_%0d: got data=%h err=%0b lat=%0d want data=%h err=0 lat=1", i, r_data, r_err, r_lat, exp[i]);
      end
    end
  endtask

  task automatic test_half_store();
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h44332211);
    issue(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF1234);
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL st_half_err: got %0b want 0", r_err); end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++; if (r_data !== 32'h44123411) begin errors++; $display("FAIL st_half_data: got %h want 44123411", r_data); end
  endtask

  task automatic test_crossing();
    issue(1'b1, 2'b10, 1'b0, 32'h0C, 32'h0C0B0A09);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h13121110);
    issue(1'b1, 2'b10, 1'b0, 32'h0E, 32'hA1B2C3D4);
`ifdef MEM_MISALIGN_SPLIT_EN
    checks++; if (r_lat != 2 || r_err !== 1'b0) begin errors++; $display("FAIL split_st: got lat=%0d err=%0b want lat=2 err=0", r_lat, r_err); end
    checks++; if (r_low != 1) begin errors++; $display("FAIL split_ready_low: got %0d cycles want 1", r_low); end
    issue(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0);
    checks++; if (r_lat != 2 || r_data !== 32'hA1B2C3D4) begin errors++; $display("FAIL split_ld: got lat=%0d data=%h want lat=2 data=a1b2c3d4", r_lat, r_data); end
    issue(1'b0, 2'b01, 1'b0, 32'h0F, 32'h0);
    checks++; if (r_data !== 32'hFFFFB2C3 || r_err !== 1'b0) begin errors++; $display("FAIL split_half: got data=%h err=%0b want ffffb2c3 err=0", r_data, r_err); end
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    checks++; if (r_data !== 32'hC3D40A09) begin errors++; $display("FAIL split_lo_word: got %h want c3d40a09", r_data); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_data !== 32'h1312A1B2) begin errors++; $display("FAIL split_hi_word: got %h want 1312a1b2", r_data); end
`else
    checks++; if (r_lat != 1 || r_err !== 1'b1 || r_data !== 32'h0) begin errors++; $display("FAIL cross_st: got lat=%0d err=%0b data=%h want lat=1 err=1 data=0", r_lat, r_err, r_data); end
    checks++; if (r_low != 0) begin errors++; $display("FAIL cross_ready_low: got %0d cycles want 0", r_low); end
    issue(1'b0, 2'b01, 1'b0, 32'h0F, 32'h0);
    checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin errors++; $display("FAIL cross_half: got err=%0b data=%h want err=1 data=0", r_err, r_data); end
    issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    checks++; if (r_data !== 32'h0C0B0A09) begin errors++; $display("FAIL cross_lo_word: got %h want 0c0b0a09", r_data); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_data !== 32'h13121110) begin errors++; $display("FAIL cross_hi_word: got %h want 13121110", r_data); end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] exp_w10;
`ifdef MEM_MISALIGN_SPLIT_EN
    exp_w10 = 32'h1312A1B2;
`else
    exp_w10 = 32'h13121110;
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    checks++; if (r_err !== 1'b1 || r_data !== 32'h0 || r_lat != 1) begin errors++; $display("FAIL oob_word: got err=%0b data=%h lat=%0d want err=1 data=0 lat=1", r_err, r_data, r_lat); end
    issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin errors++; $display("FAIL rsvd_size: got err=%0b data=%h want err=1 data=0", r_err, r_data); end
    issue(1'b1, 2'b00, 1'b0, 32'hFF, 32'h0000005A);
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL last_byte_st: got err=%0b want 0", r_err); end
    issue(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0);
    checks++; if (r_err !== 1'b0 || r_data !== 32'h0000005A) begin errors++; $display("FAIL last_byte_ld: got err=%0b data=%h want err=0 data=0000005a", r_err, r_data); end
    issue(1'b0, 2'b01, 1'b0, 32'hFF, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL half_past_end: got err=%0b want 1", r_err); end
    issue(1'b1, 2'b10, 1'b0, 32'h110, 32'h99999999);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL high_addr_st: got err=%0b want 1", r_err); end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_data !== exp_w10) begin errors++; $display("FAIL high_addr_alias: got %h want %h", r_data, exp_w10); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clock);
    #1 req_we = 1'b0; req_wdata = 32'h0;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_store_rsp: got valid=%0b err=%0b want 1/0", rsp_valid, rsp_err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", req_ready); end
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_load_valid: got %0b want 1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_load_data: got %h want cafef00d", rsp_rdata); end
  endtask

`ifdef MEM_MISALIGN_SPLIT_EN
  task automatic test_reset_split();
    issue(1'b1, 2'b10, 1'b0, 32'h2C, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h0);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h2E; req_wdata = 32'h55667788;
    @(posedge clock);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_split_state: got ready=%0b valid=%0b want 0/0", req_ready, rsp_valid); end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_split_after: got valid=%0b ready=%0b want 0/1", rsp_valid, req_ready); end
    issue(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0);
    checks++; if (r_data !== 32'h77880000) begin errors++; $display("FAIL rst_split_lo: got %h want 77880000", r_data); end
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL rst_split_hi: got %h want 00000000", r_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_half_store();
    test_crossing();
    test_errors();
    test_back_to_back();
`ifdef MEM_MISALIGN_SPLIT_EN
    test_reset_split();
`endif
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
